pipe_mux_nx1: RTL and testbench

- Parametrised N:1, WIDTH-bit operand select mux with a registered output and valid/ready handshakes on both sides.
- Succeeds the combinational 2:1 32-bit mux in the datapath.
- Sits between operand sources (register file, forwarding paths, immediates) and pipeline stages that can stall.
- A 2-entry skid buffer keeps in_ready registered, so there is no combinational ready path from out_ready to in_ready.

---
 rtl/pipe_mux_nx1.sv | 139 +++++++++++++
 tb/tb_pipe_mux_nx1.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mux_nx1.sv
// N:1 operand select mux with registered output, valid/ready on both sides and a
// 2-entry skid buffer so in_ready is registered. Optional SEL_RANGE_CHECK_EN adds sel_err.
module pipe_mux_nx1 #(
    parameter int WIDTH = 32,
    parameter int N = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N*WIDTH-1:0]   data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     q,
    output logic [SEL_W-1:0]     out_sel
`ifdef SEL_RANGE_CHECK_EN
    ,
    output logic                 sel_err
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state, state_nxt;
    logic               in_fire, out_fire;
    logic               load_main_in, load_main_skid, load_skid;
    logic [WIDTH-1:0]   skid_data_p0;
    logic [SEL_W-1:0]   skid_sel_p0;

    // Out-of-range selects fall back to input 0, or to zero when range checking is on.
    function automatic logic [WIDTH-1:0] mux_pick(input logic [SEL_W-1:0] s,
                                                  input logic [N*WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
`ifdef SEL_RANGE_CHECK_EN
        r = '0;
`else
        r = d[WIDTH-1:0];
`endif
        for (int i = 0; i < N; i++) begin
            if (s == SEL_W'(i)) r = d[i*WIDTH +: WIDTH];
        end
        return r;
    endfunction

`ifdef SEL_RANGE_CHECK_EN
    function automatic logic sel_oob(input logic [SEL_W-1:0] s);
        return 32'(s) >= N;
    endfunction
`endif

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // in_ready and out_valid are flops fed from the next state, never from out_ready directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != TWO);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_data_p0 <= '0;
            skid_sel_p0  <= '0;
        end else if (load_skid) begin
            skid_data_p0 <= mux_pick(sel, data_in);
            skid_sel_p0  <= sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q       <= '0;
            out_sel <= '0;
        end else if (load_main_in) begin
            q       <= mux_pick(sel, data_in);
            out_sel <= sel;
        end else if (load_main_skid) begin
            q       <= skid_data_p0;
            out_sel <= skid_sel_p0;
        end
    end

`ifdef SEL_RANGE_CHECK_EN
    logic skid_err_p0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_err_p0 <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            if (load_skid)           skid_err_p0 <= sel_oob(sel);
            if (load_main_in)        sel_err     <= sel_oob(sel);
            else if (load_main_skid) sel_err     <= skid_err_p0;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mux_nx1.sv
// Self-checking bench for pipe_mux_nx1: vector table, directed corner sequences and a
// randomized run against a queue-based occupancy model.
module tb_pipe_mux_nx1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  sel, out_sel;
    logic [31:0] din [4];
    logic [127:0] data_in;
    logic [31:0] q;

    logic        r_in_valid, r_in_ready, r_out_valid, r_out_ready;
    logic [1:0]  r_sel, r_out_sel;
    logic [31:0] r_din [3];
    logic [95:0] r_data;
    logic [31:0] r_q;
`ifdef SEL_RANGE_CHECK_EN
    logic        sel_err, r_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    assign data_in = {din[3], din[2], din[1], din[0]};
    assign r_data  = {r_din[2], r_din[1], r_din[0]};

    always #5 clk = ~clk;

    pipe_mux_nx1 #(.WIDTH(32), .N(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .q(q), .out_sel(out_sel)
`ifdef SEL_RANGE_CHECK_EN
        , .sel_err(sel_err)
`endif
    );

    pipe_mux_nx1 #(.WIDTH(32), .N(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .sel(r_sel), .data_in(r_data),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .q(r_q), .out_sel(r_out_sel)
`ifdef SEL_RANGE_CHECK_EN
        , .sel_err(r_err)
`endif
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] exp_q;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
    } beat_t;

    vec_t  vecs [4];
    beat_t mq [$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        logic  in_f, out_f;

        in_valid = 1'b0; out_ready = 1'b0; sel = 2'd0;
        din[0] = 32'hA5A5A5A5; din[1] = 32'h12345678;
        din[2] = 32'hDEADBEEF; din[3] = 32'h0000FFFF;
        r_in_valid = 1'b0; r_out_ready = 1'b0; r_sel = 2'd0;
        r_din[0] = 32'h11111111; r_din[1] = 32'h22222222; r_din[2] = 32'h33333333;

        vecs[0] = '{sel: 2'd2, exp_q: 32'hDEADBEEF};
        vecs[1] = '{sel: 2'd0, exp_q: 32'hA5A5A5A5};
        vecs[2] = '{sel: 2'd3, exp_q: 32'h0000FFFF};
        vecs[3] = '{sel: 2'd1, exp_q: 32'h12345678};

        // Reset asserted between edges must clear outputs immediately.
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); in_valid = 1'b1; sel = 2'd1;
        @(negedge clk); in_valid = 1'b0;
        chk1("pre_reset_valid", out_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk32("reset_q", q, 32'h0);
        chk32("reset_out_sel", 32'(out_sel), 32'h0);
        chk1("reset_in_ready", in_ready, 1'b1);
`ifdef SEL_RANGE_CHECK_EN
        chk1("reset_sel_err", sel_err, 1'b0);
`endif
        @(negedge clk); reset_n = 1'b1;

        // Single-beat select vectors.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); in_valid = 1'b1; sel = vecs[i].sel;
            @(negedge clk); in_valid = 1'b0;
            chk32("vec_q", q, vecs[i].exp_q);
            chk32("vec_out_sel", 32'(out_sel), 32'(vecs[i].sel));
            chk1("vec_out_valid", out_valid, 1'b1);
`ifdef SEL_RANGE_CHECK_EN
            chk1("vec_sel_err", sel_err, 1'b0);
`endif
            @(negedge clk);
            chk1("vec_drained", out_valid, 1'b0);
        end

        // Backpressure fills both entries, then drains in order.
        out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b1; sel = 2'd0;
        @(negedge clk); sel = 2'd1;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_out_valid", out_valid, 1'b1);
            chk32("bp_q_hold", q, 32'hA5A5A5A5);
            chk32("bp_out_sel_hold", 32'(out_sel), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk32("bp_first_out", q, 32'hA5A5A5A5);
        @(negedge clk);
        chk32("bp_second_out", q, 32'h12345678);
        chk32("bp_second_sel", 32'(out_sel), 32'd1);
        chk1("bp_second_valid", out_valid, 1'b1);
        chk1("bp_ready_back", in_ready, 1'b1);
        @(negedge clk);
        chk1("bp_empty", out_valid, 1'b0);

        // Continuous streaming at one beat per cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk32("stream_q", q, din[(i-1)%4]);
                chk32("stream_sel", 32'(out_sel), 32'((i-1)%4));
                chk1("stream_valid", out_valid, 1'b1);
            end
            chk1("stream_in_ready", in_ready, 1'b1);
            in_valid = 1'b1; sel = 2'(i % 4);
        end
        @(negedge clk); in_valid = 1'b0;
        chk32("stream_last_q", q, din[3]);
        chk1("stream_last_valid", out_valid, 1'b1);
        @(negedge clk);
        chk1("stream_done", out_valid, 1'b0);

        // Reset while full: no stale beat after release.
        out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b1; sel = 2'd2;
        @(negedge clk); sel = 2'd3;
        @(negedge clk); in_valid = 1'b0;
        chk1("full_in_ready", in_ready, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk1("midreset_out_valid", out_valid, 1'b0);
        chk1("midreset_in_ready", in_ready, 1'b1);
        chk32("midreset_q", q, 32'h0);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("no_stale_beat", out_valid, 1'b0);
        end
        in_valid = 1'b1; sel = 2'd0;
        @(negedge clk); in_valid = 1'b0;
        chk32("post_reset_q", q, 32'hA5A5A5A5);
        chk32("post_reset_sel", 32'(out_sel), 32'd0);
        chk1("post_reset_valid", out_valid, 1'b1);
        @(negedge clk);

        // Out-of-range select on the N=3 instance.
        r_out_ready = 1'b1;
        @(negedge clk); r_in_valid = 1'b1; r_sel = 2'd3;
        @(negedge clk); r_in_valid = 1'b0;
        chk1("oob_valid", r_out_valid, 1'b1);
        chk32("oob_out_sel", 32'(r_out_sel), 32'd3);
`ifdef SEL_RANGE_CHECK_EN
        chk32("oob_q", r_q, 32'h0);
        chk1("oob_sel_err", r_err, 1'b1);
`else
        chk32("oob_q", r_q, r_din[0]);
`endif
        @(negedge clk); r_in_valid = 1'b1; r_sel = 2'd1;
        @(negedge clk); r_in_valid = 1'b0;
        chk32("inrange_q", r_q, r_din[1]);
        chk1("inrange_in_ready", r_in_ready, 1'b1);
`ifdef SEL_RANGE_CHECK_EN
        chk1("inrange_sel_err", r_err, 1'b0);
`endif

        // Randomized traffic against a FIFO model of depth 2.
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            chk1("rand_in_ready", in_ready, mq.size() < 2);
            chk1("rand_out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk32("rand_q", q, mq[0].d);
                chk32("rand_out_sel", 32'(out_sel), 32'(mq[0].s));
            end
            for (int k = 0; k < 4; k++) din[k] = $urandom;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            sel       = 2'($urandom_range(0, 3));
            in_f  = in_valid && (mq.size() < 2);
            out_f = out_ready && (mq.size() > 0);
            b.d = din[sel];
            b.s = sel;
            @(posedge clk);
            if (out_f) void'(mq.pop_front());
            if (in_f) mq.push_back(b);
        end
        @(negedge clk);
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
